apb_master_bridge: RTL and testbench

//  Upstream APB requester for the GPIO subsystem. Converts a simple valid/ready request

---
 rtl/apb_pkg.sv | 7 +
 rtl/apb_master_bridge.sv | 131 +++++++++++++
 tb/tb_apb_master_bridge.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared state encoding and default bus widths for the APB master bridge.
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready request to APB SETUP/ACCESS requester with a bounded wait for pready.
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// SETUP  | psel high, penable low for one cycle
// ACCESS | psel and penable high, waiting for pready or timeout
// RESP   | response held on rsp_* until rsp_ready
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  // TIMEOUT==0 still gets a one-bit counter so the width never collapses to zero.
  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apb_state_e        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic              rsp_valid_d, rsp_err_d;

  assign req_ready = preset && (state == IDLE);

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state     <= IDLE;
      cnt       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_d       = cnt;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          pwrite_d   = req_write;
          paddr_d    = {req_addr[ADDR_W-1:2], 2'b00};
          pwdata_d   = req_wdata;
          psel_d     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        cnt_d      = '0;
        state_next = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d = pwrite ? '0 : prdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_next  = RESP;
        end else begin
          if (cnt != CNT_MAX) cnt_d = cnt + CNT_W'(1);
          // The check uses the count before this cycle's increment, giving TIMEOUT ACCESS cycles.
          if (TIMEOUT != 0 && cnt == TO_LAST) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            state_next  = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed table, corner sequences, random traffic.
module tb_apb_master_bridge;
  localparam int TIMEOUT = 16;

  logic        pclk, preset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready;

  int n_chk = 0;
  int n_err = 0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;   // ACCESS cycles with pready low before it rises
    logic [31:0] rdat;
    int          hold;    // cycles rsp_ready stays low
    int          noise;   // 0 quiet, 1 pready high outside ACCESS, 2 random noise
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] exp_pa;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Reference: pready arriving after d low cycles ends ACCESS after d+1 cycles, unless
  // the TIMEOUT-cycle limit is reached first; errors and writes return zero data.
  task automatic model(input logic wr, input logic [31:0] addr, input int delay,
                       input logic [31:0] rdat, output int acc, output logic err,
                       output logic [31:0] rd, output logic [31:0] pa);
    err = (delay >= TIMEOUT);
    acc = err ? TIMEOUT : delay + 1;
    rd  = (wr || err) ? 32'h0 : rdat;
    pa  = addr & 32'hFFFF_FFFC;
  endtask

  // Starts at a negedge in IDLE; ends at a negedge in IDLE after the response is taken.
  task automatic do_txn(input vec_t v, input bit hold_req);
    int n_psel, n_pen, lat;
    bit done;
    chkb("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    rsp_ready = 1'b0;
    pready = (v.noise == 1) ? 1'b1 : (v.noise == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge pclk);
    n_psel = 0; n_pen = 0; lat = 0; done = 0;
    while (!done && lat < 60) begin
      lat++;
      req_valid = (v.noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      if (rsp_valid) begin
        done = 1;
      end else begin
        if (psel) begin
          n_psel++;
          chk("paddr_stable", paddr, v.exp_pa);
          chkb("pwrite_stable", pwrite, v.wr);
          chk("pwdata_stable", pwdata, v.wdata);
          chkb("req_ready_busy", req_ready, 1'b0);
        end
        if (psel && penable) begin
          pready = (n_pen >= v.delay);
          prdata = (n_pen >= v.delay) ? v.rdat : $urandom;
          n_pen++;
        end else begin
          pready = (v.noise == 1) ? 1'b1 : (v.noise == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
          prdata = $urandom;
        end
        rsp_ready = (v.noise == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge pclk);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0;
    chkb("rsp_arrived", 1'(done), 1'b1);
    chk("rsp_latency", 32'(lat), 32'(v.exp_acc + 2));
    chk("psel_cycles", 32'(n_psel), 32'(v.exp_acc + 1));
    chk("penable_cycles", 32'(n_pen), 32'(v.exp_acc));
    chkb("rsp_err", rsp_err, v.exp_err);
    chk("rsp_rdata", rsp_rdata, v.exp_rd);
    chkb("psel_resp", psel, 1'b0);
    chkb("penable_resp", penable, 1'b0);
    for (int h = 0; h < v.hold; h++) begin
      if (hold_req) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
      end
      pready = 1'($urandom_range(0, 1));
      @(negedge pclk);
      chkb("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_rdata", rsp_rdata, v.exp_rd);
      chkb("hold_rsp_err", rsp_err, v.exp_err);
      chkb("hold_req_ready", req_ready, 1'b0);
      chkb("hold_psel", psel, 1'b0);
    end
    rsp_ready = 1'b1;
    pready = 1'b0;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chkb("rsp_taken", rsp_valid, 1'b0);
    chkb("back_idle_ready", req_ready, 1'b1);
    chkb("no_accept_in_resp", psel, 1'b0);
    chk("paddr_hold", paddr, v.exp_pa);
    chk("pwdata_hold", pwdata, v.wdata);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    //            wr    addr           wdata          dly  rdat           hold nz  acc err   rd             pa
    tbl[0] = '{1'b1, 32'h0000_0008, 32'hA5A5_0001,   0, 32'h0,          0,  0,  1, 1'b0, 32'h0,         32'h0000_0008};
    tbl[1] = '{1'b0, 32'h0000_0004, 32'h0,           3, 32'h1234_5678,  0,  0,  4, 1'b0, 32'h1234_5678, 32'h0000_0004};
    tbl[2] = '{1'b0, 32'h0000_0020, 32'h0,         999, 32'hDEAD_BEEF,  1,  0, 16, 1'b1, 32'h0,         32'h0000_0020};
    tbl[3] = '{1'b0, 32'h0000_0013, 32'h0,           0, 32'hCAFE_F00D,  0,  1,  1, 1'b0, 32'hCAFE_F00D, 32'h0000_0010};
    tbl[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001,  15, 32'h5555_5555,  2,  1, 16, 1'b0, 32'h0,         32'hFFFF_FFFC};
    tbl[5] = '{1'b0, 32'h0000_0100, 32'h0,          14, 32'h0000_0077,  0,  0, 15, 1'b0, 32'h0000_0077, 32'h0000_0100};

    preset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0;
    repeat (2) @(negedge pclk);
    chkb("rst_req_ready", req_ready, 1'b0);
    chkb("rst_psel", psel, 1'b0);
    chkb("rst_penable", penable, 1'b0);
    chkb("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chkb("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chkb("rst_rsp_err", rsp_err, 1'b0);
    preset = 1'b1;
    @(negedge pclk);

    for (int i = 0; i < 6; i++) do_txn(tbl[i], 1'b0);

    // Response back-pressure with a competing request held on the request side.
    rv = '{1'b0, 32'h0000_000C, 32'h0, 1, 32'h0BAD_F00D, 5, 0, 2, 1'b0, 32'h0BAD_F00D, 32'h0000_000C};
    do_txn(rv, 1'b1);
    rv = '{1'b0, 32'h0000_0040, 32'h0, 0, 32'h1111_2222, 0, 0, 1, 1'b0, 32'h1111_2222, 32'h0000_0040};
    do_txn(rv, 1'b0);

    // Reset in the middle of ACCESS abandons the transfer without a response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30; req_wdata = 32'h0; pready = 1'b0;
    @(negedge pclk);
    req_valid = 1'b0;
    chkb("mid_setup_psel", psel, 1'b1);
    chkb("mid_setup_penable", penable, 1'b0);
    @(negedge pclk);
    chkb("mid_access_penable", penable, 1'b1);
    preset = 1'b0;
    @(negedge pclk);
    chkb("mid_rst_psel", psel, 1'b0);
    chkb("mid_rst_penable", penable, 1'b0);
    chkb("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chkb("mid_rst_req_ready", req_ready, 1'b0);
    preset = 1'b1;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chkb("post_rst_no_rsp", rsp_valid, 1'b0);
      chkb("post_rst_psel", psel, 1'b0);
    end
    pready = 1'b0;
    rv = '{1'b1, 32'h0000_0034, 32'h8765_4321, 2, 32'h0, 0, 0, 3, 1'b0, 32'h0, 32'h0000_0034};
    do_txn(rv, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rv.wr    = 1'($urandom_range(0, 1));
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.delay = $urandom_range(0, 20);
      rv.rdat  = $urandom;
      rv.hold  = $urandom_range(0, 2);
      rv.noise = 2;
      model(rv.wr, rv.addr, rv.delay, rv.rdat, rv.exp_acc, rv.exp_err, rv.exp_rd, rv.exp_pa);
      do_txn(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
